// File: rtl/imm_encoder_pipe.sv
// Immediate encoder: scatters an immediate into RV32I I/S/B/U/J fields of a base word.
// Two-stage valid/ready pipeline; define IMM_ENC_STATS_EN to add the saturating err_count port.
module imm_encoder_pipe #(
    parameter bit PASS_ON_ERR = 1'b1,
    parameter int COUNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [1:0]  out_cause
`ifdef IMM_ENC_STATS_EN
    ,
    output logic [COUNT_W-1:0] err_count
`endif
);

    localparam logic [1:0]  C_NONE  = 2'd0;
    localparam logic [1:0]  C_RANGE = 2'd1;
    localparam logic [1:0]  C_ALIGN = 2'd2;
    localparam logic [1:0]  C_FMT   = 2'd3;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        s1_valid;
    logic [31:0] s1_base;
    logic [31:0] s1_field;
    logic [31:0] s1_mask;
    logic [1:0]  s1_cause;
    logic        s2_valid;
    logic        s1_adv;
    logic        s2_adv;

    logic        fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
    logic        ok11, ok12, ok20;
    logic [31:0] field;
    logic [31:0] mask;
    logic [1:0]  cause;
    logic [31:0] merged;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = rst_n && s1_adv;
    assign out_valid = s2_valid;

    assign fmt_i = (in_fmt == 3'd0);
    assign fmt_s = (in_fmt == 3'd1);
    assign fmt_b = (in_fmt == 3'd2);
    assign fmt_u = (in_fmt == 3'd3);
    assign fmt_j = (in_fmt == 3'd4);

    // Sign-extension checks: upper bits must all copy the top encodable bit.
    assign ok11 = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign ok12 = (&in_imm[31:12]) || !(|in_imm[31:12]);
    assign ok20 = (&in_imm[31:20]) || !(|in_imm[31:20]);

    always_comb begin
        field = '0;
        mask  = '0;
        cause = C_NONE;
        unique case (1'b1)
            fmt_i: begin
                mask  = 32'hFFF0_0000;
                field = {in_imm[11:0], 20'b0};
                if (!ok11) cause = C_RANGE;
            end
            fmt_s: begin
                mask  = 32'hFE00_0F80;
                field = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
                if (!ok11) cause = C_RANGE;
            end
            fmt_b: begin
                mask  = 32'hFE00_0F80;
                field = {in_imm[12], in_imm[10:5], 13'b0,
                         in_imm[4:1], in_imm[11], 7'b0};
                if (in_imm[0])  cause = C_ALIGN;
                else if (!ok12) cause = C_RANGE;
            end
            fmt_u: begin
                mask  = 32'hFFFF_F000;
                field = {in_imm[31:12], 12'b0};
                if (|in_imm[11:0]) cause = C_ALIGN;
            end
            fmt_j: begin
                mask  = 32'hFFFF_F000;
                field = {in_imm[20], in_imm[10:1], in_imm[11],
                         in_imm[19:12], 12'b0};
                if (in_imm[0])  cause = C_ALIGN;
                else if (!ok20) cause = C_RANGE;
            end
            default: cause = C_FMT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_base  <= '0;
            s1_field <= '0;
            s1_mask  <= '0;
            s1_cause <= C_NONE;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_base  <= in_base;
                s1_field <= field;
                s1_mask  <= mask;
                s1_cause <= cause;
            end
        end
    end

    // Bad format has an empty mask, so the merge alone yields in_base.
    always_comb begin
        merged = (s1_base & ~s1_mask) | s1_field;
        if (!PASS_ON_ERR && s1_cause != C_NONE) merged = NOP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            out_cause <= C_NONE;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= merged;
                out_err   <= (s1_cause != C_NONE);
                out_cause <= s1_cause;
            end
        end
    end

`ifdef IMM_ENC_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (s2_valid && out_ready && out_err && !(&err_count)) begin
            err_count <= err_count + COUNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_imm_encoder_pipe.sv
// Directed bench for imm_encoder_pipe: field scatter, legality causes, latency,
// backpressure ordering and reset flush; err_count checked when IMM_ENC_STATS_EN is set.
module tb_imm_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [1:0]  out_cause;
    logic        in_ready0;
    logic        out_valid0;
    logic [31:0] out_instr0;
    logic        out_err0;
    logic [1:0]  out_cause0;
`ifdef IMM_ENC_STATS_EN
    logic [15:0] err_count;
    logic [15:0] err_count0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_encoder_pipe #(.PASS_ON_ERR(1'b1), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_imm(in_imm), .in_base(in_base),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .out_cause(out_cause)
`ifdef IMM_ENC_STATS_EN
        , .err_count(err_count)
`endif
    );

    imm_encoder_pipe #(.PASS_ON_ERR(1'b0), .COUNT_W(16)) dut_nop (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_fmt(in_fmt), .in_imm(in_imm), .in_base(in_base),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_instr(out_instr0), .out_err(out_err0), .out_cause(out_cause0)
`ifdef IMM_ENC_STATS_EN
        , .err_count(err_count0)
`endif
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_one(input logic [2:0] f, input logic [31:0] imm,
                           input logic [31:0] base, input logic [31:0] e1,
                           input logic ee, input logic [1:0] ec,
                           input string tag);
        logic [31:0] e0;
        e0 = ee ? 32'h0000_0013 : e1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_fmt    = f;
        in_imm    = imm;
        in_base   = base;
        #1;
        chk(32'(in_ready), 32'd1, {tag, "_ready"});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk(32'(out_valid), 32'd0, {tag, "_early"});
        @(posedge clk); #1;
        chk(32'(out_valid), 32'd1, {tag, "_valid"});
        chk(out_instr, e1, {tag, "_instr"});
        chk(out_instr0, e0, {tag, "_instr_nop"});
        chk(32'(out_err), 32'(ee), {tag, "_err"});
        chk(32'(out_cause), 32'(ec), {tag, "_cause"});
        @(posedge clk); #1;
        chk(32'(out_valid), 32'd0, {tag, "_drain"});
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [2:0]  s_fmt  [8];
    logic [31:0] s_imm  [8];
    logic [31:0] s_base [8];
    logic [31:0] s_exp  [8];
    logic        s_err  [8];

    initial begin
        int idx, ridx;
        logic saw_low, hold_v, acc, stale;
        logic [31:0] hold_i;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_fmt    = '0;
        in_imm    = '0;
        in_base   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk(32'(out_valid), 32'd0, "rst_valid");
        chk(out_instr, 32'd0, "rst_instr");
        chk(32'(out_err), 32'd0, "rst_err");
        chk(32'(out_cause), 32'd0, "rst_cause");
        rst_n = 1'b1;
        #1;
        chk(32'(in_ready), 32'd1, "rst_ready");
        @(posedge clk); #1;

        run_one(3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0, 2'd0, "i_neg1");
        run_one(3'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0, 2'd0, "i_min");
        run_one(3'd0, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0, 2'd0, "i_max");
        run_one(3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1, 2'd1, "i_range");
        run_one(3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0, 2'd0, "b_neg4");
        run_one(3'd2, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1, 2'd1, "b_range");
        run_one(3'd2, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 1'b0, 2'd0, "b_min");
        run_one(3'd2, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0, 2'd0, "b_max");
        run_one(3'd2, 32'h0000_1001, 32'h0000_0063, 32'h8000_0063, 1'b1, 2'd2, "b_prio");
        run_one(3'd1, 32'hFFFF_FFF8, 32'h0000_2023, 32'hFE00_2C23, 1'b0, 2'd0, "s_neg8");
        run_one(3'd3, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0, 2'd0, "u_ok");
        run_one(3'd3, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1, 2'd2, "u_align");
        run_one(3'd4, 32'h0000_0801, 32'h0000_006F, 32'h0010_006F, 1'b1, 2'd2, "j_align");
        run_one(3'd4, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0, 2'd0, "j_min");
        run_one(3'd4, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0, 2'd0, "j_max");
        run_one(3'd4, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1, 2'd1, "j_range");
        run_one(3'd6, 32'h0000_0004, 32'h0000_006F, 32'h0000_006F, 1'b1, 2'd3, "bad_fmt6");
        run_one(3'd5, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1, 2'd3, "bad_fmt5");

        s_fmt[0] = 3'd0; s_imm[0] = 32'h0000_0001; s_base[0] = 32'h0000_0013;
        s_exp[0] = 32'h0010_0013; s_err[0] = 1'b0;
        s_fmt[1] = 3'd0; s_imm[1] = 32'h0000_07FF; s_base[1] = 32'h0000_0013;
        s_exp[1] = 32'h7FF0_0013; s_err[1] = 1'b0;
        s_fmt[2] = 3'd0; s_imm[2] = 32'hFFFF_F800; s_base[2] = 32'h0000_0013;
        s_exp[2] = 32'h8000_0013; s_err[2] = 1'b0;
        s_fmt[3] = 3'd2; s_imm[3] = 32'h0000_1000; s_base[3] = 32'h0000_0063;
        s_exp[3] = 32'h8000_0063; s_err[3] = 1'b1;
        s_fmt[4] = 3'd1; s_imm[4] = 32'hFFFF_FFF8; s_base[4] = 32'h0000_2023;
        s_exp[4] = 32'hFE00_2C23; s_err[4] = 1'b0;
        s_fmt[5] = 3'd4; s_imm[5] = 32'h000F_FFFE; s_base[5] = 32'h0000_006F;
        s_exp[5] = 32'h7FFF_F06F; s_err[5] = 1'b0;
        s_fmt[6] = 3'd3; s_imm[6] = 32'h0000_0001; s_base[6] = 32'h0000_0037;
        s_exp[6] = 32'h0000_0037; s_err[6] = 1'b1;
        s_fmt[7] = 3'd2; s_imm[7] = 32'h0000_0FFE; s_base[7] = 32'h0000_0063;
        s_exp[7] = 32'h7E00_0FE3; s_err[7] = 1'b0;

        do_reset();
        idx     = 0;
        ridx    = 0;
        saw_low = 1'b0;
        hold_v  = 1'b0;
        hold_i  = '0;
        for (int cyc = 0; cyc < 40 && ridx < 8; cyc++) begin
            in_valid = (idx < 8);
            if (idx < 8) begin
                in_fmt  = s_fmt[idx];
                in_imm  = s_imm[idx];
                in_base = s_base[idx];
            end
            out_ready = !(cyc >= 3 && cyc < 6);
            #1;
            if (in_valid && !in_ready) saw_low = 1'b1;
            if (hold_v) chk(out_instr, hold_i, "stream_hold");
            hold_v = out_valid && !out_ready;
            hold_i = out_instr;
            if (out_valid && out_ready) begin
                chk(out_instr, s_exp[ridx], $sformatf("stream_instr%0d", ridx));
                chk(out_instr0, s_err[ridx] ? 32'h0000_0013 : s_exp[ridx],
                    $sformatf("stream_nop%0d", ridx));
                chk(32'(out_err), 32'(s_err[ridx]), $sformatf("stream_err%0d", ridx));
                ridx++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk(32'(ridx), 32'd8, "stream_count");
        chk(32'(saw_low), 32'd1, "stream_ready_drop");
        stale = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        chk(32'(stale), 32'd0, "stream_no_dup");
`ifdef IMM_ENC_STATS_EN
        chk(32'(err_count), 32'd2, "stream_err_count");
`endif

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 3'd0;
        in_imm    = 32'h0000_0005;
        in_base   = 32'h0000_0013;
        @(posedge clk); #1;
        in_imm = 32'h0000_0800;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk(32'(out_valid), 32'd1, "flush_pre");
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_imm   = 32'h0000_0007;
        @(posedge clk); #1;
        chk(32'(out_valid), 32'd0, "flush_valid");
        chk(out_instr, 32'd0, "flush_instr");
        chk(32'(out_err), 32'd0, "flush_err");
`ifdef IMM_ENC_STATS_EN
        chk(32'(err_count), 32'd0, "flush_err_count");
`endif
        in_valid  = 1'b0;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale     = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid || out_valid0) stale = 1'b1;
        end
        chk(32'(stale), 32'd0, "flush_no_stale");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_encoder_pipe.md
Name: imm_encoder_pipe

Overview:
- Inverse of the immediate decode units: takes a 32-bit immediate value, a format code and a base instruction word, and scatters the immediate into the RV32I I/S/B/U/J bit positions.
- Checks range and alignment, and flags any immediate that the format cannot represent.
- Two-stage valid/ready pipeline, used by the instruction patch/assembly path (branch-target fixup, test-program generation).

Parameters:
- PASS_ON_ERR, 1, 1: on error, out_instr carries the truncated encoding. 0: out_instr is forced to 32'h00000013 (NOP).
- COUNT_W, 16, width of the optional error counter.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_fmt  input  3  0=I, 1=S, 2=B, 3=U, 4=J, 5..7 illegal
- in_imm  input  32  immediate value (byte offset for B/J)
- in_base  input  32  instruction word; non-immediate fields are preserved
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_instr  output  32  encoded instruction
- out_err  output  1  encoding error
- out_cause  output  2  0=none, 1=range, 2=alignment, 3=bad format
- err_count  output  COUNT_W  present only with IMM_ENC_STATS_EN

Behaviour:
- Reset (rst_n low at a clk edge):
  - Stage valids clear, so out_valid=0.
  - out_instr=0, out_err=0, out_cause=0.
  - In-flight items are discarded.
  - in_ready=1 from the first cycle after reset is released.
- Pipeline:
  - Stage 1 registers the checks and the field extract; stage 2 registers the merged word.
  - Output appears 2 cycles after acceptance when out_ready=1. Throughput is 1 per cycle.
  - Stage 2 advances when !s2_valid || out_ready.
  - Stage 1 advances when !s1_valid || the stage-2 advance condition.
  - in_ready = !s1_valid || stage-1 advance. No bubble is inserted under continuous flow.
- Outputs are stable while out_valid && !out_ready. Ordering is strictly FIFO, with no loss and no duplication.
- Encoding. Bits not listed are taken from in_base:
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - U: [31:12]=imm[31:12]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
- Legality checks:
  - I/S: imm[31:11] all equal, otherwise range error.
  - B: imm[0]=0, otherwise alignment error; imm[31:12] all equal, otherwise range error.
  - U: imm[11:0]=0, otherwise alignment error.
  - J: imm[0]=0, otherwise alignment error; imm[31:20] all equal, otherwise range error.
- Cause priority: bad format > alignment > range.
- Bad format: out_instr = in_base when PASS_ON_ERR=1, and the NOP otherwise.
- Boundaries that must pass:
  - I: imm=-2048 and +2047
  - B: -4096 and +4094
  - J: -1048576 and +1048574
- Reset asserted concurrently with in_valid: the request is not accepted.

Optional Feature:
- Macro: IMM_ENC_STATS_EN.
- With the macro defined:
  - err_count port exists.
  - It increments by 1 on each output handshake with out_err=1.
  - It saturates at all-ones and resets to 0.
- Without the macro: the port and its logic are absent, and the remaining behaviour is identical.

Test Plan:
- I fmt, base 0x00000013, imm 0xFFFFFFFF, out_ready=1 -> out_instr 0xFFF00013, err 0, out_valid exactly 2 cycles after acceptance.
- B fmt, base 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3, err 0. Then imm 0x00001000 -> out_err 1, cause 1.
- U fmt, base 0x00000037, imm 0x12345000 -> 0x12345037. Then imm 0x12345001 -> cause 2.
- J fmt, base 0x0000006F, imm 0x00000801 -> cause 2. Then fmt 6 -> cause 3, out_instr 0x0000006F with PASS_ON_ERR=1, 0x00000013 with PASS_ON_ERR=0.
- Back-to-back stream of 8 requests, out_ready low for 3 cycles mid-stream:
  - in_ready drops once both stages are full.
  - All 8 outputs arrive in order, unchanged, none dropped or repeated.
  - With IMM_ENC_STATS_EN and 2 erroring items, err_count=2.
- Reset pulsed with 2 items in flight -> out_valid 0 the next cycle, no stale output afterwards, err_count 0.
